instruction_fetch_queue: RTL

Parametrised instruction fetch front end that replaces direct PC-to-instruction_memory coupling.
- Owns the fetch PC and issues word addresses to a synchronous-read instruction memory.
- Tracks in-flight reads over a configurable memory latency and buffers returned instructions, with their PCs, in a DEPTH-entry queue.
- Presents them to decode through a valid/ready handshake, and supports branch redirect with flush of queued and in-flight fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/instruction_fetch_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared sizing helpers for the instruction fetch front end.
package fetch_pkg;

  // Width able to hold the counts 0..depth (occupancy, credits in use).
  function automatic int occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a read/write pointer into a depth-entry store; at least one bit.
  function automatic int ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous first-word-fall-through FIFO with single-cycle flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_W = 48,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic [DATA_W-1:0]             i_push_data,
  input  logic                          i_pop,
  output logic                          o_valid,
  output logic [DATA_W-1:0]             o_data,
  output logic [occ_width(DEPTH)-1:0]   o_count
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_count;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;

  // Flush dominates both push and pop; pop only takes effect on a valid head.
  assign w_valid = (r_count != '0);
  assign w_pop   = i_pop && w_valid && !i_flush;
  assign w_push  = i_push && !i_flush;

  // Entry storage; contents are only observed while qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presented combinationally; zero when empty.
  always_comb begin
    o_valid = w_valid;
    o_data  = w_valid ? r_mem[r_head] : '0;
    o_count = r_count;
  end

  // Upstream credit accounting must never push into a full queue without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n || i_flush)
                                   !(i_push && !w_pop && (r_count == FULL)));

endmodule

// File: rtl/instruction_fetch_queue.sv
// Fetch front end: owns the PC, issues reads under a credit limit, tracks
// in-flight reads and queues returned instructions for decode.
module instruction_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned           INSTR_WIDTH = 16,
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 4,
  parameter int unsigned           MEM_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fetch_en,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [INSTR_WIDTH-1:0]       mem_rdata,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);
  localparam int unsigned SUM_W = OCC_W + 1;
  localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] pc;
  } inflight_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  inflight_t             r_line [MEM_LATENCY];
  logic [OCC_W-1:0]      r_inflight_cnt;
  logic [OCC_W-1:0]      w_occ;
  logic [SUM_W-1:0]      w_used;
  logic                  w_issue;
  logic                  w_retire;
  logic                  w_head_valid;
  entry_t                w_push_entry;
  entry_t                w_head;

  // Credits in use come from registered counts only; a same-cycle pop frees nothing.
  assign w_used   = SUM_W'(w_occ) + SUM_W'(r_inflight_cnt);
  assign w_issue  = rst_n && fetch_en && !redirect_valid && (w_used < CREDITS);
  assign w_retire = r_line[MEM_LATENCY-1].valid;

  assign w_push_entry = '{pc: r_line[MEM_LATENCY-1].pc, instr: mem_rdata};

  // Fetch PC: reset wins over redirect, redirect wins over sequential issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_issue) begin
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end
  end

  // In-flight shift line: the last stage lines up with mem_rdata.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        r_line[i] <= '0;
      end
    end else begin
      r_line[0] <= '{valid: w_issue, pc: r_fetch_pc};
      for (int i = 1; i < int'(MEM_LATENCY); i++) begin
        r_line[i] <= r_line[i-1];
      end
    end
  end

  // Count of valid in-flight entries, kept alongside the shift line.
  always_ff @(posedge clk) begin
    if (!rst_n || redirect_valid) begin
      r_inflight_cnt <= '0;
    end else begin
      case ({w_issue, w_retire})
        2'b10:   r_inflight_cnt <= r_inflight_cnt + 1'b1;
        2'b01:   r_inflight_cnt <= r_inflight_cnt - 1'b1;
        default: r_inflight_cnt <= r_inflight_cnt;
      endcase
    end
  end

  fetch_fifo #(
    .DATA_W (ADDR_WIDTH + INSTR_WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_retire),
    .i_push_data (w_push_entry),
    .i_pop       (out_ready),
    .o_valid     (w_head_valid),
    .o_data      (w_head),
    .o_count     (w_occ)
  );

  // Memory request and decode-facing outputs.
  always_comb begin
    mem_rd_en = w_issue;
    mem_addr  = r_fetch_pc;
    out_valid = w_head_valid;
    out_instr = w_head.instr;
    out_pc    = w_head.pc;
    occupancy = w_occ;
  end

endmodule
